// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types for the instruction fetch unit: FSM states, opcode attributes,
// segment register indices, prefix byte values and the assembled instruction record.
`default_nettype none

package instruction_fetch_unit_pkg;

  typedef enum logic [2:0] {
    S_OPCODE = 3'd0,
    S_MODRM  = 3'd1,
    S_DISP   = 3'd2,
    S_IMM    = 3'd3,
    S_DONE   = 3'd4
  } ifu_state_e;

  typedef enum logic [1:0] {
    DS1 = 2'd0,
    PS  = 2'd1,
    SS  = 2'd2,
    DS0 = 2'd3
  } sreg_index_e;

  typedef struct packed {
    logic       is_prefix;
    logic       has_modrm;
    logic [2:0] imm_size;
    logic       group_f6;
  } opcode_attr_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [3:0]  len;
    sreg_index_e sreg;
    logic        seg_ovr;
    logic [1:0]  rep;
    logic        lock;
    logic [7:0]  opcode;
    logic [7:0]  modrm;
    logic [15:0] disp;
    logic [31:0] imm;
  } ifu_rec_t;

  localparam logic [7:0] PFX_DS1   = 8'h26;
  localparam logic [7:0] PFX_PS    = 8'h2E;
  localparam logic [7:0] PFX_SS    = 8'h36;
  localparam logic [7:0] PFX_DS0   = 8'h3E;
  localparam logic [7:0] PFX_LOCK  = 8'hF0;
  localparam logic [7:0] PFX_REPNE = 8'hF2;
  localparam logic [7:0] PFX_REP   = 8'hF3;

  function automatic logic [1:0] disp_size(input logic [7:0] modrm);
    unique case (modrm[7:6])
      2'b00:   return (modrm[2:0] == 3'b110) ? 2'd2 : 2'd0;
      2'b01:   return 2'd1;
      2'b10:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic ifu_state_e after_operands(input logic [2:0] imm_size);
    return (imm_size != 3'd0) ? S_IMM : S_DONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_fetch_unit_if.sv
// Prefetch-queue, branch and instruction-record signals between the fetch unit
// (master) and the bus control / execution units (slave).
`default_nettype none

interface instruction_fetch_unit_if;
  import instruction_fetch_unit_pkg::*;

  logic             ce_1;
  logic             ce_2;
  logic [7:0][7:0]  ipq;
  logic [3:0]       ipq_len;
  logic [15:0]      ipq_head;
  logic             pfp_set;
  logic             set_pc;
  logic [15:0]      new_pc;
  logic             instr_valid;
  logic             instr_ready;
  logic [15:0]      instr_pc;
  logic [3:0]       instr_len;
  sreg_index_e      instr_sreg;
  logic             instr_seg_ovr;
  logic [1:0]       instr_rep;
  logic             instr_lock;
  logic [7:0]       instr_opcode;
  logic [7:0]       instr_modrm;
  logic [15:0]      instr_disp;
  logic [31:0]      instr_imm;
  logic             ifu_fault;

  modport master (
    input  ce_1, ce_2, ipq, ipq_len, set_pc, new_pc, instr_ready,
    output ipq_head, pfp_set, instr_valid, instr_pc, instr_len, instr_sreg,
           instr_seg_ovr, instr_rep, instr_lock, instr_opcode, instr_modrm,
           instr_disp, instr_imm, ifu_fault
  );

  modport slave (
    output ce_1, ce_2, ipq, ipq_len, set_pc, new_pc, instr_ready,
    input  ipq_head, pfp_set, instr_valid, instr_pc, instr_len, instr_sreg,
           instr_seg_ovr, instr_rep, instr_lock, instr_opcode, instr_modrm,
           instr_disp, instr_imm, ifu_fault
  );

endinterface

`default_nettype wire

// File: rtl/instruction_fetch_unit_opcode_attr_rom.sv
// Combinational opcode attribute table: prefix flag, ModR/M presence, immediate size
// and the F6/F7 group flag whose immediate depends on the ModR/M reg field.
`default_nettype none

module opcode_attr_rom
  import instruction_fetch_unit_pkg::*;
(
  input  logic [7:0]   opcode_i,
  output opcode_attr_t attr_o
);

  always_comb begin
    attr_o = '0;
    casez (opcode_i)
      8'h26, 8'h2E, 8'h36, 8'h3E,
      8'hF0, 8'hF2, 8'hF3:          attr_o.is_prefix = 1'b1;
      8'b00???0??, 8'h62, 8'hC4, 8'hC5,
      8'b100001??, 8'b10001???,
      8'b110100??, 8'b11011???,
      8'hFE, 8'hFF:                 attr_o.has_modrm = 1'b1;
      8'b00???100, 8'h6A, 8'b0111????, 8'hA8, 8'b10110???,
      8'hCD, 8'hD4, 8'hD5, 8'b11100???, 8'hEB:
                                    attr_o.imm_size = 3'd1;
      8'b00???101, 8'h68, 8'hA9, 8'b101000??, 8'b10111???,
      8'hC2, 8'hCA, 8'hE8, 8'hE9:   attr_o.imm_size = 3'd2;
      8'hC8:                        attr_o.imm_size = 3'd3;
      8'h9A, 8'hEA:                 attr_o.imm_size = 3'd4;
      8'h80, 8'h82, 8'h83, 8'h6B, 8'hC0, 8'hC1, 8'hC6: begin
        attr_o.has_modrm = 1'b1;
        attr_o.imm_size  = 3'd1;
      end
      8'h81, 8'h69, 8'hC7: begin
        attr_o.has_modrm = 1'b1;
        attr_o.imm_size  = 3'd2;
      end
      8'hF6, 8'hF7: begin
        attr_o.has_modrm = 1'b1;
        attr_o.group_f6  = 1'b1;
      end
      default: attr_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// Consumes prefetch-queue bytes one per ce_1, assembles a decoded instruction
// record and offers it to the execution unit; branches flush the queue.
`default_nettype none

module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int MAX_PREFIX = 4
)(
  input  logic                      clk,
  input  logic                      reset,
  instruction_fetch_unit_if.master  bus
);

  localparam int CW = $clog2(MAX_PREFIX + 2);

  ifu_state_e    state_q, state_d;
  ifu_rec_t      rec_q, rec_d;
  logic [15:0]   head_q, head_d;
  logic          pfp_q, pfp_d;
  logic          fault_q, fault_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dsz_q, dsz_d;
  logic [2:0]    isz_q, isz_d;
  logic [1:0]    idx_q, idx_d;
  logic          grp_q, grp_d;
  logic [7:0]    w_byte;
  logic [2:0]    w_imm_eff;
  opcode_attr_t  w_attr;

  assign w_byte = bus.ipq[head_q[2:0]];

  opcode_attr_rom u_attr_rom (
    .opcode_i (w_byte),
    .attr_o   (w_attr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_OPCODE;
      rec_q   <= '0;
      head_q  <= '0;
      pfp_q   <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
      dsz_q   <= '0;
      isz_q   <= '0;
      idx_q   <= '0;
      grp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rec_q   <= rec_d;
      head_q  <= head_d;
      pfp_q   <= pfp_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
      dsz_q   <= dsz_d;
      isz_q   <= isz_d;
      idx_q   <= idx_d;
      grp_q   <= grp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rec_d     = rec_q;
    head_d    = head_q;
    pfp_d     = pfp_q;
    fault_d   = fault_q;
    cnt_d     = cnt_q;
    dsz_d     = dsz_q;
    isz_d     = isz_q;
    idx_d     = idx_q;
    grp_d     = grp_q;
    w_imm_eff = isz_q;
    if (bus.ce_1) begin
      pfp_d = 1'b0;
      // Branch wins over everything, including a handshake on the same ce_1.
      if (bus.set_pc) begin
        head_d  = bus.new_pc;
        pfp_d   = 1'b1;
        state_d = S_OPCODE;
        fault_d = 1'b0;
        rec_d   = '0;
        cnt_d   = '0;
        idx_d   = '0;
      end else if (state_q == S_DONE) begin
        if (bus.instr_ready) begin
          rec_d   = '0;
          cnt_d   = '0;
          state_d = S_OPCODE;
        end
      end else if (!pfp_q && !fault_q && bus.ipq_len != 4'd0) begin
        head_d    = head_q + 16'd1;
        rec_d.len = rec_q.len + 4'd1;
        if (rec_q.len == 4'd0) rec_d.pc = head_q;
        unique case (state_q)
          S_OPCODE: begin
            if (w_attr.is_prefix) begin
              cnt_d = cnt_q + CW'(1);
              if (cnt_d == CW'(MAX_PREFIX + 1)) fault_d = 1'b1;
              case (w_byte)
                PFX_DS1:   begin rec_d.sreg = DS1; rec_d.seg_ovr = 1'b1; end
                PFX_PS:    begin rec_d.sreg = PS;  rec_d.seg_ovr = 1'b1; end
                PFX_SS:    begin rec_d.sreg = SS;  rec_d.seg_ovr = 1'b1; end
                PFX_DS0:   begin rec_d.sreg = DS0; rec_d.seg_ovr = 1'b1; end
                PFX_LOCK:  rec_d.lock = 1'b1;
                PFX_REPNE: rec_d.rep  = 2'd2;
                PFX_REP:   rec_d.rep  = 2'd3;
                default:   rec_d.lock = rec_q.lock;
              endcase
            end else begin
              rec_d.opcode = w_byte;
              grp_d        = w_attr.group_f6;
              isz_d        = w_attr.imm_size;
              idx_d        = '0;
              state_d      = w_attr.has_modrm ? S_MODRM : after_operands(w_attr.imm_size);
            end
          end
          S_MODRM: begin
            rec_d.modrm = w_byte;
            dsz_d       = disp_size(w_byte);
            // F6/F7 carry an immediate only for the TEST form (reg field 000).
            if (grp_q) w_imm_eff = (w_byte[5:3] == 3'b000) ? (rec_q.opcode[0] ? 3'd2 : 3'd1) : 3'd0;
            isz_d   = w_imm_eff;
            state_d = (dsz_d != 2'd0) ? S_DISP : after_operands(w_imm_eff);
          end
          S_DISP: begin
            if (idx_q == 2'd0) rec_d.disp = {{8{w_byte[7]}}, w_byte};
            else               rec_d.disp[15:8] = w_byte;
            idx_d = idx_q + 2'd1;
            if (idx_q + 2'd1 == dsz_q) begin
              idx_d   = '0;
              state_d = after_operands(isz_q);
            end
          end
          S_IMM: begin
            rec_d.imm[{idx_q, 3'b000} +: 8] = w_byte;
            idx_d = idx_q + 2'd1;
            if ({1'b0, idx_q} + 3'd1 == isz_q) begin
              idx_d   = '0;
              state_d = S_DONE;
            end
          end
          default: state_d = S_OPCODE;
        endcase
      end
    end
  end

  assign bus.ipq_head      = head_q;
  assign bus.pfp_set       = pfp_q;
  assign bus.ifu_fault     = fault_q;
  assign bus.instr_valid   = (state_q == S_DONE);
  assign bus.instr_pc      = rec_q.pc;
  assign bus.instr_len     = rec_q.len;
  assign bus.instr_sreg    = rec_q.sreg;
  assign bus.instr_seg_ovr = rec_q.seg_ovr;
  assign bus.instr_rep     = rec_q.rep;
  assign bus.instr_lock    = rec_q.lock;
  assign bus.instr_opcode  = rec_q.opcode;
  assign bus.instr_modrm   = rec_q.modrm;
  assign bus.instr_disp    = rec_q.disp;
  assign bus.instr_imm     = rec_q.imm;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a byte-memory model stands in for the
// bus control unit's prefetch queue; every expected value is hand-computed.
`default_nettype none

module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] qlen;
  logic [7:0] mem [1024];
  int         checks = 0;
  int         errors = 0;

  instruction_fetch_unit_if bus();

  instruction_fetch_unit #(.MAX_PREFIX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Queue model: slot k maps to the byte at the head's 8-byte block; empty while flushing.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      logic [2:0] ks;
      ks = k[2:0];
      bus.ipq[k] = mem[{bus.ipq_head[9:3], ks}];
    end
    bus.ipq_len = bus.pfp_set ? 4'd0 : qlen;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; qlen = 4'd0; bus.ce_1 = 1'b1; bus.ce_2 = 1'b0;
    bus.set_pc = 1'b0; bus.new_pc = 16'h0; bus.instr_ready = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    tick(2);
    checks++; if (bus.ipq_head !== 16'h0000) begin errors++; $display("FAIL reset_head: got %h expected 0000", bus.ipq_head); end
    checks++; if (bus.pfp_set !== 1'b0) begin errors++; $display("FAIL reset_pfp: got %b expected 0", bus.pfp_set); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.instr_valid); end
    checks++; if (bus.ifu_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", bus.ifu_fault); end
    checks++; if (bus.instr_len !== 4'd0 || bus.instr_opcode !== 8'h00 || bus.instr_imm !== 32'h0)
      begin errors++; $display("FAIL reset_record: got len %0d op %h imm %h expected 0", bus.instr_len, bus.instr_opcode, bus.instr_imm); end
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_nop;
    mem[0] = 8'h90; qlen = 4'd8; bus.instr_ready = 1'b1;
    tick(1);
    checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL nop_valid: got %b expected 1", bus.instr_valid); end
    checks++; if (bus.instr_opcode !== 8'h90 || bus.instr_len !== 4'd1 || bus.instr_pc !== 16'h0000)
      begin errors++; $display("FAIL nop_record: got op %h len %0d pc %h expected 90 1 0000", bus.instr_opcode, bus.instr_len, bus.instr_pc); end
    checks++; if (bus.ipq_head !== 16'h0001) begin errors++; $display("FAIL nop_head: got %h expected 0001", bus.ipq_head); end
    qlen = 4'd0;
    tick(1);
    checks++; if (bus.instr_valid !== 1'b0 || bus.ipq_head !== 16'h0001 || bus.instr_opcode !== 8'h00)
      begin errors++; $display("FAIL nop_handshake: got valid %b head %h op %h expected 0 0001 00", bus.instr_valid, bus.ipq_head, bus.instr_opcode); end
  endtask

  task automatic test_modrm_disp8;
    mem[1] = 8'h2E; mem[2] = 8'h8B; mem[3] = 8'h46; mem[4] = 8'hFC;
    qlen = 4'd8; bus.instr_ready = 1'b0;
    tick(3);
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL disp8_early_valid: got %b expected 0", bus.instr_valid); end
    tick(1);
    checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL disp8_valid: got %b expected 1", bus.instr_valid); end
    checks++; if (bus.instr_seg_ovr !== 1'b1 || bus.instr_sreg !== PS)
      begin errors++; $display("FAIL disp8_seg: got ovr %b sreg %0d expected 1 1", bus.instr_seg_ovr, bus.instr_sreg); end
    checks++; if (bus.instr_opcode !== 8'h8B || bus.instr_modrm !== 8'h46 || bus.instr_disp !== 16'hFFFC)
      begin errors++; $display("FAIL disp8_fields: got op %h modrm %h disp %h expected 8B 46 FFFC", bus.instr_opcode, bus.instr_modrm, bus.instr_disp); end
    checks++; if (bus.instr_len !== 4'd4 || bus.instr_pc !== 16'h0001 || bus.ipq_head !== 16'h0005)
      begin errors++; $display("FAIL disp8_len: got len %0d pc %h head %h expected 4 0001 0005", bus.instr_len, bus.instr_pc, bus.ipq_head); end
    bus.instr_ready = 1'b1; qlen = 4'd0;
    tick(1);
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL disp8_release: got %b expected 0", bus.instr_valid); end
  endtask

  task automatic test_hold;
    mem[5] = 8'hC7; mem[6] = 8'h06; mem[7] = 8'h34; mem[8] = 8'h12; mem[9] = 8'h78; mem[10] = 8'h56;
    qlen = 4'd8; bus.instr_ready = 1'b0;
    tick(6);
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_disp !== 16'h1234 || bus.instr_imm !== 32'h0000_5678 || bus.instr_len !== 4'd6)
      begin errors++; $display("FAIL hold_record: got valid %b disp %h imm %h len %0d expected 1 1234 00005678 6", bus.instr_valid, bus.instr_disp, bus.instr_imm, bus.instr_len); end
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checks++; if (bus.instr_valid !== 1'b1 || bus.ipq_head !== 16'h000B || bus.instr_imm !== 32'h0000_5678)
        begin errors++; $display("FAIL hold_stable: cycle %0d got valid %b head %h imm %h expected 1 000B 00005678", i, bus.instr_valid, bus.ipq_head, bus.instr_imm); end
    end
    bus.instr_ready = 1'b1; qlen = 4'd0;
    tick(1);
  endtask

  task automatic test_empty_stall;
    mem[11] = 8'hEA; mem[12] = 8'h00; mem[13] = 8'h01; mem[14] = 8'h00; mem[15] = 8'hF0;
    qlen = 4'd8; bus.instr_ready = 1'b0;
    tick(3);
    qlen = 4'd0;
    tick(3);
    checks++; if (bus.ipq_head !== 16'h000E || bus.instr_valid !== 1'b0)
      begin errors++; $display("FAIL stall_hold: got head %h valid %b expected 000E 0", bus.ipq_head, bus.instr_valid); end
    qlen = 4'd8;
    tick(2);
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_imm !== 32'hF000_0100 || bus.instr_len !== 4'd5 || bus.instr_pc !== 16'h000B)
      begin errors++; $display("FAIL stall_resume: got valid %b imm %h len %0d pc %h expected 1 F0000100 5 000B", bus.instr_valid, bus.instr_imm, bus.instr_len, bus.instr_pc); end
    bus.instr_ready = 1'b1; qlen = 4'd0;
    tick(1);
  endtask

  task automatic test_ce_gate;
    mem[16] = 8'h90; qlen = 4'd8; bus.instr_ready = 1'b0; bus.ce_1 = 1'b0;
    tick(2);
    checks++; if (bus.ipq_head !== 16'h0010 || bus.instr_valid !== 1'b0)
      begin errors++; $display("FAIL ce_gate_idle: got head %h valid %b expected 0010 0", bus.ipq_head, bus.instr_valid); end
    bus.ce_1 = 1'b1;
    tick(1);
    checks++; if (bus.instr_valid !== 1'b1 || bus.ipq_head !== 16'h0011 || bus.instr_pc !== 16'h0010)
      begin errors++; $display("FAIL ce_gate_run: got valid %b head %h pc %h expected 1 0011 0010", bus.instr_valid, bus.ipq_head, bus.instr_pc); end
    bus.instr_ready = 1'b1; qlen = 4'd0;
    tick(1);
  endtask

  task automatic test_set_pc;
    mem[17] = 8'h2E; mem[18] = 8'h8B; mem[19] = 8'h46; mem[20] = 8'hFC; mem[512] = 8'h90;
    qlen = 4'd8; bus.instr_ready = 1'b0;
    tick(2);
    bus.set_pc = 1'b1; bus.new_pc = 16'h0200;
    tick(1);
    checks++; if (bus.pfp_set !== 1'b1 || bus.ipq_head !== 16'h0200 || bus.instr_valid !== 1'b0 || bus.instr_len !== 4'd0)
      begin errors++; $display("FAIL branch_flush: got pfp %b head %h valid %b len %0d expected 1 0200 0 0", bus.pfp_set, bus.ipq_head, bus.instr_valid, bus.instr_len); end
    bus.set_pc = 1'b0;
    tick(1);
    checks++; if (bus.pfp_set !== 1'b0 || bus.ipq_head !== 16'h0200)
      begin errors++; $display("FAIL branch_pulse: got pfp %b head %h expected 0 0200", bus.pfp_set, bus.ipq_head); end
    tick(1);
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0200 || bus.instr_opcode !== 8'h90)
      begin errors++; $display("FAIL branch_next: got valid %b pc %h op %h expected 1 0200 90", bus.instr_valid, bus.instr_pc, bus.instr_opcode); end
    bus.instr_ready = 1'b1; qlen = 4'd0;
    tick(1);
  endtask

  task automatic test_prefix_fault;
    for (int i = 513; i < 518; i++) mem[i] = 8'hF3;
    mem[518] = 8'h90;
    qlen = 4'd8; bus.instr_ready = 1'b0;
    tick(4);
    checks++; if (bus.ifu_fault !== 1'b0 || bus.ipq_head !== 16'h0205 || bus.instr_rep !== 2'd3)
      begin errors++; $display("FAIL fault_before: got fault %b head %h rep %0d expected 0 0205 3", bus.ifu_fault, bus.ipq_head, bus.instr_rep); end
    tick(1);
    checks++; if (bus.ifu_fault !== 1'b1 || bus.ipq_head !== 16'h0206)
      begin errors++; $display("FAIL fault_raise: got fault %b head %h expected 1 0206", bus.ifu_fault, bus.ipq_head); end
    tick(3);
    checks++; if (bus.ifu_fault !== 1'b1 || bus.ipq_head !== 16'h0206 || bus.instr_valid !== 1'b0)
      begin errors++; $display("FAIL fault_frozen: got fault %b head %h valid %b expected 1 0206 0", bus.ifu_fault, bus.ipq_head, bus.instr_valid); end
    bus.set_pc = 1'b1; bus.new_pc = 16'h0300;
    tick(1);
    checks++; if (bus.ifu_fault !== 1'b0 || bus.pfp_set !== 1'b1 || bus.ipq_head !== 16'h0300 || bus.instr_rep !== 2'd0)
      begin errors++; $display("FAIL fault_clear: got fault %b pfp %b head %h rep %0d expected 0 1 0300 0", bus.ifu_fault, bus.pfp_set, bus.ipq_head, bus.instr_rep); end
    bus.set_pc = 1'b0;
  endtask

  task automatic test_prefix_override;
    mem[768] = 8'h26; mem[769] = 8'hF2; mem[770] = 8'h3E; mem[771] = 8'hF3; mem[772] = 8'h90;
    mem[773] = 8'hF0; mem[774] = 8'h90;
    qlen = 4'd8; bus.instr_ready = 1'b0;
    tick(1);
    tick(5);
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_sreg !== DS0 || bus.instr_seg_ovr !== 1'b1 || bus.instr_rep !== 2'd3 || bus.instr_lock !== 1'b0)
      begin errors++; $display("FAIL override_prefix: got valid %b sreg %0d ovr %b rep %0d lock %b expected 1 3 1 3 0", bus.instr_valid, bus.instr_sreg, bus.instr_seg_ovr, bus.instr_rep, bus.instr_lock); end
    checks++; if (bus.instr_len !== 4'd5 || bus.instr_pc !== 16'h0300 || bus.ipq_head !== 16'h0305)
      begin errors++; $display("FAIL override_len: got len %0d pc %h head %h expected 5 0300 0305", bus.instr_len, bus.instr_pc, bus.ipq_head); end
    bus.instr_ready = 1'b1;
    tick(1);
    bus.instr_ready = 1'b0;
    tick(2);
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_lock !== 1'b1 || bus.instr_len !== 4'd2 || bus.instr_pc !== 16'h0305 || bus.instr_seg_ovr !== 1'b0)
      begin errors++; $display("FAIL lock_record: got valid %b lock %b len %0d pc %h ovr %b expected 1 1 2 0305 0", bus.instr_valid, bus.instr_lock, bus.instr_len, bus.instr_pc, bus.instr_seg_ovr); end
    bus.instr_ready = 1'b1; bus.set_pc = 1'b1; bus.new_pc = 16'h0040;
    tick(1);
    checks++; if (bus.ipq_head !== 16'h0040 || bus.pfp_set !== 1'b1 || bus.instr_valid !== 1'b0 || bus.instr_lock !== 1'b0)
      begin errors++; $display("FAIL branch_priority: got head %h pfp %b valid %b lock %b expected 0040 1 0 0", bus.ipq_head, bus.pfp_set, bus.instr_valid, bus.instr_lock); end
    bus.set_pc = 1'b0; bus.instr_ready = 1'b0; qlen = 4'd0;
    tick(1);
    checks++; if (bus.pfp_set !== 1'b0 || bus.ipq_head !== 16'h0040)
      begin errors++; $display("FAIL branch_priority_end: got pfp %b head %h expected 0 0040", bus.pfp_set, bus.ipq_head); end
  endtask

  initial begin
    test_reset();
    test_nop();
    test_modrm_disp8();
    test_hold();
    test_empty_stall();
    test_ce_gate();
    test_set_pc();
    test_prefix_fault();
    test_prefix_override();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Sits directly downstream of the bus control unit's 8-byte instruction prefetch queue.
- Owns the queue head pointer (`ipq_head`) and consumes queue bytes one at a time.
- Assembles prefixes, opcode, ModR/M, displacement and immediate into one instruction record, handed to the execution unit over a valid/ready handshake.
- Performs queue flush (`pfp_set`) on execution-unit branch requests.

Parameters:
- MAX_PREFIX, 4, number of prefix bytes accepted before `ifu_fault` is raised.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ce_1  in  1  phase-1 clock enable; all state advances only on ce_1
- ce_2  in  1  phase-2 clock enable; unused except as a pass-through qualifier, no state change
- ipq  in  8x8  prefetch queue bytes, indexed by `ipq_head[2:0]`
- ipq_len  in  4  valid bytes in queue (0..8)
- ipq_head  out  16  offset of next byte to consume
- pfp_set  out  1  flush request; BCU reloads its prefetch pointer from `ipq_head`
- set_pc  in  1  branch request from execution unit
- new_pc  in  16  branch target offset
- instr_valid  out  1  record valid
- instr_ready  in  1  execution unit accepts record
- instr_pc  out  16  offset of first byte (first prefix if any)
- instr_len  out  4  total bytes consumed
- instr_sreg  out  sreg_index_e  segment override value
- instr_seg_ovr  out  1  segment override present
- instr_rep  out  2  0 none, 2 REPNE (F2), 3 REP (F3)
- instr_lock  out  1  buslock prefix (F0) present
- instr_opcode  out  8  opcode byte
- instr_modrm  out  8  ModR/M byte (0 if none)
- instr_disp  out  16  displacement; 8-bit displacement is sign-extended
- instr_imm  out  32  immediate bytes, little-endian from bit 0
- ifu_fault  out  1  prefix overflow; sticky until reset or set_pc

Behaviour:
- Reset: `ipq_head`=0, `pfp_set`=0, state=S_OPCODE, `instr_valid`=0, `ifu_fault`=0, all record fields 0.
- Byte available iff `ipq_len` != 0. Current byte = `ipq[ipq_head[2:0]]`.
- Consuming a byte: `ipq_head` += 1 (16-bit wrap), `instr_len` += 1. At most one byte consumed per ce_1.
- Between records, the first consumed byte latches `instr_pc` = `ipq_head`.
- S_OPCODE:
  - Prefix bytes 26/2E/36/3E set `instr_sreg` (DS1/PS/SS/DS0) and `instr_seg_ovr`. F2/F3 set `instr_rep`; F0 sets `instr_lock`. A later prefix overrides an earlier one of the same class. Stay in S_OPCODE.
  - Prefix count reaching MAX_PREFIX+1 sets `ifu_fault` and halts consumption.
  - A non-prefix byte latches `instr_opcode` and looks up attributes. Next state: S_MODRM if has_modrm; else S_IMM if imm_size>0; else S_DONE.
- S_MODRM: latch the byte. disp_size: mod=00 & rm=110 → 2; mod=01 → 1; mod=10 → 2; otherwise 0. Next state: S_DISP if disp_size>0, else S_IMM/S_DONE as above.
  - Group F6/F7 with reg=000 have imm_size 1/2; other reg values have imm_size 0.
- S_DISP: collect disp_size bytes, low byte first. Next state: S_IMM/S_DONE.
- S_IMM: collect imm_size bytes (1, 2, 3 for PREPARE/ENTER, 4 for far ptr) into `instr_imm[8k+7:8k]`. Then S_DONE.
- S_DONE: `instr_valid`=1; record held stable and no bytes consumed.
  - On ce_1 with `instr_ready`: clear `instr_valid` and all record fields, go to S_OPCODE.
  - That ce_1 may not also consume a byte, so peak throughput is one record per (len+1) ce_1.
- Empty queue in any collecting state: hold state, no consumption.
- `set_pc` (sampled on ce_1) has priority over everything, including a simultaneous handshake:
  - `ipq_head` ← `new_pc`, `pfp_set`=1 for exactly that ce_1 period, cleared on the next ce_1.
  - State ← S_OPCODE; partial or valid record discarded; `instr_valid` ← 0; `ifu_fault` ← 0.
  - While `pfp_set`=1 no bytes are consumed (BCU reports `ipq_len`=0).
- The execution unit must not drop `instr_ready` semantics mid-cycle: ready is sampled only on ce_1.

Decomposition:
- Shared types package:
  - `ifu_state_e` (S_OPCODE, S_MODRM, S_DISP, S_IMM, S_DONE).
  - `opcode_attr_t` {is_prefix, has_modrm, imm_size[2:0], group_f6}.
  - Prefix byte constants.
  - Reuse existing `sreg_index_e`.
- Sub-module `opcode_attr_rom`: combinational 256-entry lookup, opcode → `opcode_attr_t`.

Test Plan:
- Queue holds 90 (NOP) at head 0x0000, `instr_ready`=1 → record `opcode`=90, `len`=1, `pc`=0000; `ipq_head`=0001 after 1 ce_1.
- Bytes 2E 8B 46 FC → `seg_ovr`=1, `sreg`=PS, `opcode`=8B, `modrm`=46, `disp`=FFFC, `len`=4, 4 ce_1 to valid.
- Bytes C7 06 34 12 78 56 → `disp`=1234, `imm`=00005678, `len`=6; hold `instr_ready`=0 for 5 ce_1 → record stable, `ipq_head` unchanged.
- Bytes EA 00 01 00 F0 with `ipq_len` dropping to 0 after byte 3 → stall in S_IMM; resumes when `len`>0; `imm`=F0000100.
- Mid-record (after 2 of 4 bytes) `set_pc`, `new_pc`=0x0200 → `pfp_set` pulse one ce_1, `ipq_head`=0200, `instr_valid`=0, next record `pc`=0200.
- Five F3 prefixes with MAX_PREFIX=4 → `ifu_fault`=1 after the 5th, `ipq_head` frozen; `set_pc` clears the fault.
